cr_osf_seq_merge: RTL and testbench

- Parametrised output-sequencing merger for the OSF outbound path.
- Drains NUM_SRC TLV source FIFOs into one outbound FIFO, following a programmable slot sequence; each slot names a source and a TLV count.
- Generalises the fixed data-then-PDT alternation to N sources, multi-TLV segments, per-source debug hold, a TLV-aligned enable/drain and protocol-error status.
- Sits between the per-source outbound FIFOs and the OSF output FIFO.

---
 rtl/cr_osf_seq_merge_pkg.sv | 16 +
 rtl/cr_osf_seq_merge_trk.sv | 76 +++++++
 rtl/cr_osf_seq_merge.sv | 152 +++++++++++++++
 tb/tb_cr_osf_seq_merge.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cr_osf_seq_merge_pkg.sv
// Shared types and constants for the OSF outbound sequencing merger.
package cr_osf_seq_merge_pkg;

  localparam int OSF_SEQ_MAX_DEPTH = 16;
  localparam int OSF_SEQ_SRC_W     = 3;  // wide enough for up to 8 sources
  localparam int OSF_SEQ_CNT_W     = 8;  // holds any supported CNT_W

  localparam int OSF_TUSER_SOT = 0;
  localparam int OSF_TUSER_EOT = 1;

  typedef struct packed {
    logic [OSF_SEQ_SRC_W-1:0] src;
    logic [OSF_SEQ_CNT_W-1:0] cnt;
  } osf_seq_slot_t;

endpackage

// File: rtl/cr_osf_seq_merge_trk.sv
// Per-transfer TLV tracker: open-TLV flag, eot count within the current slot, sticky protocol error.
// Registered state only; slot advance is combinational from the current transfer.
module cr_osf_seq_merge_trk #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             xfer,
  input  logic             sot,
  input  logic             eot,
  input  logic             hold,
  input  logic             skip,
  input  logic [CNT_W-1:0] eff_cnt,
  input  logic             err_clr,
  output logic             in_tlv,
  output logic [CNT_W-1:0] eot_cnt,
  output logic             err,
  output logic             adv
);

  logic             in_tlv_q, in_tlv_d;
  logic [CNT_W-1:0] eot_cnt_q, eot_cnt_d;
  logic             err_q, err_d;
  logic             err_set;
  logic [CNT_W:0]   eot_nxt;

  always_comb begin
    in_tlv_d  = in_tlv_q;
    eot_cnt_d = eot_cnt_q;
    err_set   = 1'b0;
    adv       = 1'b0;
    eot_nxt   = {1'b0, eot_cnt_q} + (CNT_W+1)'(1);
    if (xfer) begin
      if (eot) begin
        in_tlv_d = 1'b0;
      end else if (sot) begin
        in_tlv_d = 1'b1;
      end
      err_set = (sot && in_tlv_q) || (eot && !in_tlv_q && !sot);
      if (eot) begin
        // >= rather than == so a count left above a shrunk eff_cnt, or a
        // released hold, still closes the slot on this eot.
        if (eot_nxt >= {1'b0, eff_cnt}) begin
          if (hold) begin
            eot_cnt_d = eff_cnt;
          end else begin
            eot_cnt_d = '0;
            adv       = 1'b1;
          end
        end else begin
          eot_cnt_d = eot_cnt_q + CNT_W'(1);
        end
      end
    end else if (skip) begin
      eot_cnt_d = '0;
    end
    err_d = err_clr ? 1'b0 : (err_q || err_set);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_tlv_q  <= 1'b0;
      eot_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      in_tlv_q  <= in_tlv_d;
      eot_cnt_q <= eot_cnt_d;
      err_q     <= err_d;
    end
  end

  assign in_tlv  = in_tlv_q;
  assign eot_cnt = eot_cnt_q;
  assign err     = err_q;

endmodule

// File: rtl/cr_osf_seq_merge.sv
// Drains NUM_SRC TLV source FIFOs into the OSF output FIFO following a programmable slot sequence.
// Zero-latency pop/write when source non-empty and output not full; strict order, waits on empty source.
module cr_osf_seq_merge #(
  parameter int NUM_SRC   = 2,
  parameter int DATA_W    = 64,
  parameter int SEQ_DEPTH = 4,
  parameter int SRC_W     = $clog2(NUM_SRC),
  parameter int CNT_W     = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_SRC*DATA_W-1:0]        src_tdata,
  input  logic [NUM_SRC*2-1:0]             src_tuser,
  input  logic [NUM_SRC-1:0]               src_empty,
  output logic [NUM_SRC-1:0]               src_rd,
  input  logic                             ob_fifo_full,
  output logic                             ob_fifo_wr,
  output logic [DATA_W+1:0]                ob_fifo_wdata,
  input  logic                             cfg_enable,
  input  logic [$clog2(SEQ_DEPTH+1)-1:0]   cfg_seq_len,
  input  logic [SEQ_DEPTH*SRC_W-1:0]       cfg_slot_src,
  input  logic [SEQ_DEPTH*CNT_W-1:0]       cfg_slot_cnt,
  input  logic [NUM_SRC-1:0]               cfg_dbg_hold,
  output logic [$clog2(SEQ_DEPTH)-1:0]     stat_ptr,
  output logic                             stat_idle,
  output logic [31:0]                      stat_beats,
  output logic                             stat_err,
  input  logic                             stat_err_clr
);

  import cr_osf_seq_merge_pkg::*;

  localparam int PTR_W = $clog2(SEQ_DEPTH);
  localparam int LEN_W = $clog2(SEQ_DEPTH+1);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [31:0]      beats_q, beats_d;

  osf_seq_slot_t    cur_slot;
  logic             cur_valid;
  logic [CNT_W-1:0] slot_cnt, eff_cnt;
  logic [LEN_W-1:0] eff_len;

  logic [DATA_W-1:0] sel_dat;
  logic [1:0]        sel_user;
  logic              sel_empty;
  logic              sel_hold;

  logic             run, go, skip, advance;
  logic             trk_in_tlv, trk_err, trk_adv;
  logic [CNT_W-1:0] trk_eot_cnt;

  always_comb begin
    cur_slot     = '0;
    cur_slot.src = OSF_SEQ_SRC_W'(cfg_slot_src[int'(ptr_q)*SRC_W +: SRC_W]);
    cur_slot.cnt = OSF_SEQ_CNT_W'(cfg_slot_cnt[int'(ptr_q)*CNT_W +: CNT_W]);
    cur_valid    = int'(cur_slot.src) < NUM_SRC;
    slot_cnt     = CNT_W'(cur_slot.cnt);
    eff_cnt      = (slot_cnt == '0) ? CNT_W'(1) : slot_cnt;
  end

  always_comb begin
    if (cfg_seq_len == '0) begin
      eff_len = LEN_W'(1);
    end else if (int'(cfg_seq_len) > SEQ_DEPTH) begin
      eff_len = LEN_W'(SEQ_DEPTH);
    end else begin
      eff_len = cfg_seq_len;
    end
  end

  // Out-of-range slot sources match no index and leave the mux at its default.
  always_comb begin
    sel_dat   = '0;
    sel_user  = '0;
    sel_empty = 1'b1;
    sel_hold  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cur_valid && int'(cur_slot.src) == i) begin
        sel_dat   = src_tdata[i*DATA_W +: DATA_W];
        sel_user  = src_tuser[2*i +: 2];
        sel_empty = src_empty[i];
        sel_hold  = cfg_dbg_hold[i];
      end
    end
  end

  assign run     = cfg_enable || trk_in_tlv || (trk_eot_cnt != '0);
  assign go      = rst_n && run && cur_valid && !sel_empty && !ob_fifo_full;
  assign skip    = rst_n && run && !cur_valid;
  assign advance = skip || trk_adv;

  always_comb begin
    src_rd = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_rd[i] = go && (int'(cur_slot.src) == i);
    end
  end

  assign ob_fifo_wr    = go;
  assign ob_fifo_wdata = {sel_user, sel_dat};

  cr_osf_seq_merge_trk #(
    .CNT_W (CNT_W)
  ) u_trk (
    .clk     (clk),
    .rst_n   (rst_n),
    .xfer    (go),
    .sot     (sel_user[OSF_TUSER_SOT]),
    .eot     (sel_user[OSF_TUSER_EOT]),
    .hold    (sel_hold),
    .skip    (skip),
    .eff_cnt (eff_cnt),
    .err_clr (stat_err_clr),
    .in_tlv  (trk_in_tlv),
    .eot_cnt (trk_eot_cnt),
    .err     (trk_err),
    .adv     (trk_adv)
  );

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      // Also pulls a pointer left beyond a shortened sequence back to slot 0.
      if (int'(ptr_q) + 1 >= int'(eff_len)) begin
        ptr_d = '0;
      end else begin
        ptr_d = ptr_q + PTR_W'(1);
      end
    end
    beats_d = beats_q;
    if (go && (beats_q != 32'hFFFF_FFFF)) begin
      beats_d = beats_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      beats_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      beats_q <= beats_d;
    end
  end

  assign stat_ptr   = ptr_q;
  assign stat_beats = beats_q;
  assign stat_err   = trk_err;
  assign stat_idle  = !cfg_enable && !trk_in_tlv && (trk_eot_cnt == '0);

endmodule

// File: tb/tb_cr_osf_seq_merge.sv
// Directed bench: combinational vector table from reset state, then multi-cycle sequences.
module tb_cr_osf_seq_merge;

  logic        clk, rst_n;
  logic [47:0] src_tdata;
  logic [5:0]  src_tuser;
  logic [2:0]  src_empty, src_rd;
  logic        ob_fifo_full, ob_fifo_wr;
  logic [17:0] ob_fifo_wdata;
  logic        cfg_enable;
  logic [2:0]  cfg_seq_len;
  logic [7:0]  cfg_slot_src;
  logic [15:0] cfg_slot_cnt;
  logic [2:0]  cfg_dbg_hold;
  logic [1:0]  stat_ptr;
  logic        stat_idle, stat_err, stat_err_clr;
  logic [31:0] stat_beats;

  cr_osf_seq_merge #(
    .NUM_SRC(3), .DATA_W(16), .SEQ_DEPTH(4), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .src_tdata(src_tdata), .src_tuser(src_tuser), .src_empty(src_empty), .src_rd(src_rd),
    .ob_fifo_full(ob_fifo_full), .ob_fifo_wr(ob_fifo_wr), .ob_fifo_wdata(ob_fifo_wdata),
    .cfg_enable(cfg_enable), .cfg_seq_len(cfg_seq_len), .cfg_slot_src(cfg_slot_src),
    .cfg_slot_cnt(cfg_slot_cnt), .cfg_dbg_hold(cfg_dbg_hold),
    .stat_ptr(stat_ptr), .stat_idle(stat_idle), .stat_beats(stat_beats),
    .stat_err(stat_err), .stat_err_clr(stat_err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Queue entry layout matches ob_fifo_wdata: {eot, sot, data}.
  logic [17:0] q0[$], q1[$], q2[$];
  logic [17:0] obs_q[$], exp_q[$];
  logic [2:0]  rd_s;
  logic        wr_s;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic update_heads();
    src_empty = {q2.size() == 0, q1.size() == 0, q0.size() == 0};
    src_tdata = '0;
    src_tuser = '0;
    if (q0.size() > 0) begin src_tdata[15:0]  = q0[0][15:0]; src_tuser[1:0] = q0[0][17:16]; end
    if (q1.size() > 0) begin src_tdata[31:16] = q1[0][15:0]; src_tuser[3:2] = q1[0][17:16]; end
    if (q2.size() > 0) begin src_tdata[47:32] = q2[0][15:0]; src_tuser[5:4] = q2[0][17:16]; end
  endtask

  task automatic push(input int s, input logic [17:0] e, input bit expect_out);
    case (s)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
    if (expect_out) exp_q.push_back(e);
    update_heads();
  endtask

  task automatic tlv(input int s, input int n, input logic [15:0] base, input bit expect_out);
    for (int k = 0; k < n; k++) begin
      logic [17:0] e;
      e = {1'(k == n-1), 1'(k == 0), 16'(base + 16'(k))};
      push(s, e, expect_out);
    end
  endtask

  task automatic set_slot(input int k, input logic [1:0] s, input logic [3:0] c);
    cfg_slot_src[k*2 +: 2] = s;
    cfg_slot_cnt[k*4 +: 4] = c;
  endtask

  // Sample at negedge, let the DUT act on posedge, then pop what it read.
  task automatic tick();
    @(negedge clk);
    rd_s = src_rd;
    wr_s = ob_fifo_wr;
    if (ob_fifo_wr) obs_q.push_back(ob_fifo_wdata);
    @(posedge clk);
    #1;
    if (rd_s[0] && q0.size() > 0) void'(q0.pop_front());
    if (rd_s[1] && q1.size() > 0) void'(q1.pop_front());
    if (rd_s[2] && q2.size() > 0) void'(q2.pop_front());
    update_heads();
  endtask

  task automatic run_until(input string nm, input int n, input int budget);
    for (int k = 0; k < budget && obs_q.size() < n; k++) tick();
    chk({nm, "_count"}, 64'(obs_q.size()), 64'(n));
  endtask

  task automatic chk_stream(input string nm);
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s_beat%0d", nm, i),
          (i < obs_q.size()) ? 64'(obs_q[i]) : 64'hFFFF_FFFF_FFFF_FFFF, 64'(exp_q[i]));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    q0.delete(); q1.delete(); q2.delete();
    obs_q.delete(); exp_q.delete();
    update_heads();
    ob_fifo_full = 1'b0; cfg_enable = 1'b0; cfg_seq_len = 3'd2;
    cfg_slot_src = '0; cfg_slot_cnt = '0; cfg_dbg_hold = '0; stat_err_clr = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  slot_src;
    logic        en;
    logic [2:0]  empty;
    logic        full;
    logic [2:0]  exp_rd;
    logic        exp_wr;
    logic        wchk;
    logic [17:0] exp_wdata;
    logic        exp_idle;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{2'd0, 1'b1, 3'b000, 1'b0, 3'b001, 1'b1, 1'b1, 18'h100A0, 1'b0};
    vecs[1]  = '{2'd1, 1'b1, 3'b000, 1'b0, 3'b010, 1'b1, 1'b1, 18'h300B1, 1'b0};
    vecs[2]  = '{2'd2, 1'b1, 3'b000, 1'b0, 3'b100, 1'b1, 1'b1, 18'h200C2, 1'b0};
    vecs[3]  = '{2'd0, 1'b1, 3'b001, 1'b0, 3'b000, 1'b0, 1'b1, 18'h100A0, 1'b0};
    vecs[4]  = '{2'd1, 1'b1, 3'b101, 1'b0, 3'b010, 1'b1, 1'b1, 18'h300B1, 1'b0};
    vecs[5]  = '{2'd0, 1'b1, 3'b000, 1'b1, 3'b000, 1'b0, 1'b1, 18'h100A0, 1'b0};
    vecs[6]  = '{2'd0, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1, 18'h100A0, 1'b1};
    vecs[7]  = '{2'd3, 1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 18'h00000, 1'b0};
    vecs[8]  = '{2'd2, 1'b1, 3'b011, 1'b0, 3'b100, 1'b1, 1'b1, 18'h200C2, 1'b0};
    vecs[9]  = '{2'd2, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1, 18'h200C2, 1'b1};
    vecs[10] = '{2'd1, 1'b1, 3'b010, 1'b1, 3'b000, 1'b0, 1'b1, 18'h300B1, 1'b0};

    rst_n = 1'b0;
    ob_fifo_full = 1'b0; cfg_enable = 1'b0; cfg_seq_len = 3'd2;
    cfg_slot_src = '0; cfg_slot_cnt = '0; cfg_dbg_hold = '0; stat_err_clr = 1'b0;
    src_tdata = '0; src_tuser = '0; src_empty = '1;
    repeat (2) @(posedge clk);

    // Each vector is applied from fresh reset state and checked before the next edge.
    foreach (vecs[v]) begin
      @(negedge clk);
      rst_n = 1'b0;
      src_tdata = {16'h00C2, 16'h00B1, 16'h00A0};
      src_tuser = {2'b10, 2'b11, 2'b01};
      src_empty = vecs[v].empty;
      ob_fifo_full = vecs[v].full;
      cfg_enable = vecs[v].en;
      cfg_slot_src = {6'b0, vecs[v].slot_src};
      #1 rst_n = 1'b1;
      #1;
      chk($sformatf("v%0d_rd", v), 64'(src_rd), 64'(vecs[v].exp_rd));
      chk($sformatf("v%0d_wr", v), 64'(ob_fifo_wr), 64'(vecs[v].exp_wr));
      if (vecs[v].wchk) chk($sformatf("v%0d_wdata", v), 64'(ob_fifo_wdata), 64'(vecs[v].exp_wdata));
      chk($sformatf("v%0d_idle", v), 64'(stat_idle), 64'(vecs[v].exp_idle));
      chk($sformatf("v%0d_ptr", v), 64'(stat_ptr), 64'd0);
      chk($sformatf("v%0d_beats", v), 64'(stat_beats), 64'd0);
      chk($sformatf("v%0d_err", v), 64'(stat_err), 64'd0);
      #1 rst_n = 1'b0;
    end

    // Two-source alternation with multi-beat TLVs.
    do_reset();
    set_slot(0, 2'd0, 4'd1); set_slot(1, 2'd1, 4'd1); cfg_seq_len = 3'd2; cfg_enable = 1'b1;
    tlv(0, 3, 16'h0100, 1); tlv(1, 2, 16'h1100, 1);
    tlv(0, 3, 16'h0200, 1); tlv(1, 2, 16'h1200, 1);
    run_until("alt", 10, 40);
    chk_stream("alt");
    chk("alt_beats", 64'(stat_beats), 64'd10);
    chk("alt_ptr", 64'(stat_ptr), 64'd0);

    // Two-TLV slot on src2 finishes before src0 is touched.
    do_reset();
    set_slot(0, 2'd2, 4'd2); set_slot(1, 2'd0, 4'd1); cfg_seq_len = 3'd2; cfg_enable = 1'b1;
    tlv(2, 1, 16'h2000, 1); tlv(2, 1, 16'h2001, 1); tlv(0, 1, 16'h0300, 1);
    run_until("multi2", 2, 20);
    chk("multi_ptr", 64'(stat_ptr), 64'd1);
    run_until("multi3", 3, 20);
    chk_stream("multi");

    // Output full on the eot beat stalls pop, write and advance.
    do_reset();
    set_slot(0, 2'd0, 4'd1); set_slot(1, 2'd1, 4'd1); cfg_seq_len = 3'd2; cfg_enable = 1'b1;
    tlv(0, 2, 16'h0400, 1);
    tick();
    ob_fifo_full = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("full%0d_rd", k), 64'(rd_s), 64'd0);
      chk($sformatf("full%0d_wr", k), 64'(wr_s), 64'd0);
      chk($sformatf("full%0d_ptr", k), 64'(stat_ptr), 64'd0);
    end
    ob_fifo_full = 1'b0;
    tick();
    chk("full_rel_wr", 64'(wr_s), 64'd1);
    chk("full_rel_ptr", 64'(stat_ptr), 64'd1);
    chk_stream("full");

    // Disable mid-TLV: the open TLV completes, then nothing more is read.
    do_reset();
    set_slot(0, 2'd0, 4'd1); set_slot(1, 2'd1, 4'd1); cfg_seq_len = 3'd2; cfg_enable = 1'b1;
    tlv(0, 4, 16'h0500, 1); tlv(1, 1, 16'h1500, 0);
    tick(); tick();
    cfg_enable = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("dis_count", 64'(obs_q.size()), 64'd4);
    chk_stream("dis");
    chk("dis_rd", 64'(rd_s), 64'd0);
    chk("dis_idle", 64'(stat_idle), 64'd1);
    chk("dis_q1_left", 64'(q1.size()), 64'd1);

    // Debug hold keeps the slot on src1 across several TLVs.
    do_reset();
    set_slot(0, 2'd0, 4'd1); set_slot(1, 2'd1, 4'd1); cfg_seq_len = 3'd2; cfg_enable = 1'b1;
    cfg_dbg_hold = 3'b010;
    tlv(0, 1, 16'h0600, 1);
    tlv(1, 1, 16'h1600, 1); tlv(1, 1, 16'h1601, 1); tlv(1, 1, 16'h1602, 1);
    run_until("hold4", 4, 30);
    chk("hold_ptr", 64'(stat_ptr), 64'd1);
    cfg_dbg_hold = 3'b000;
    tlv(1, 1, 16'h1603, 1);
    run_until("hold5", 5, 20);
    chk("hold_rel_ptr", 64'(stat_ptr), 64'd0);
    chk_stream("hold");

    // Double sot raises a sticky error; the clear pulse drops it.
    do_reset();
    set_slot(0, 2'd0, 4'd1); cfg_seq_len = 3'd1; cfg_enable = 1'b1;
    push(0, {1'b0, 1'b1, 16'h0700}, 1);
    push(0, {1'b0, 1'b1, 16'h0701}, 1);
    push(0, {1'b1, 1'b0, 16'h0702}, 1);
    tick();
    chk("err_first_sot", 64'(stat_err), 64'd0);
    tick();
    chk("err_set", 64'(stat_err), 64'd1);
    tick(); tick();
    chk("err_sticky", 64'(stat_err), 64'd1);
    stat_err_clr = 1'b1;
    tick();
    stat_err_clr = 1'b0;
    chk("err_clr", 64'(stat_err), 64'd0);

    // Async reset with a TLV open and the pointer moved.
    do_reset();
    set_slot(0, 2'd2, 4'd1); set_slot(1, 2'd0, 4'd1); cfg_seq_len = 3'd2; cfg_enable = 1'b1;
    push(2, {1'b1, 1'b0, 16'h2800}, 1);
    push(0, {1'b0, 1'b1, 16'h0800}, 1);
    push(0, {1'b1, 1'b0, 16'h0801}, 1);
    tick(); tick();
    chk("rst_pre_ptr", 64'(stat_ptr), 64'd1);
    chk("rst_pre_beats", 64'(stat_beats), 64'd2);
    chk("rst_pre_err", 64'(stat_err), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ptr", 64'(stat_ptr), 64'd0);
    chk("rst_beats", 64'(stat_beats), 64'd0);
    chk("rst_err", 64'(stat_err), 64'd0);
    chk("rst_rd", 64'(src_rd), 64'd0);
    chk("rst_wr", 64'(ob_fifo_wr), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

endmodule
